// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the hex-to-segment decode used by the scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-low (common-anode bank).
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
    logic [6:0] segBits;
    segBits = SEG_BLANK;
    case (nibble)
      4'h0: segBits = 7'b1000000;
      4'h1: segBits = 7'b1111001;
      4'h2: segBits = 7'b0100100;
      4'h3: segBits = 7'b0110000;
      4'h4: segBits = 7'b0011001;
      4'h5: segBits = 7'b0010010;
      4'h6: segBits = 7'b0000010;
      4'h7: segBits = 7'b1111000;
      4'h8: segBits = 7'b0000000;
      4'h9: segBits = 7'b0010000;
      4'hA: segBits = 7'b0001000;
      4'hB: segBits = 7'b0000011;
      4'hC: segBits = 7'b1000110;
      4'hD: segBits = 7'b0100001;
      4'hE: segBits = 7'b0000110;
      4'hF: segBits = 7'b0001110;
      default: segBits = SEG_BLANK;
    endcase
    return segBits;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  import seg_pkg::*;

  assign o_seg = hexToSeg(i_nibble);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode seven-segment scanner with per-digit enable/dp,
// leading-zero blanking, PWM brightness and frame-aligned (tear-free) updates.
module seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_BITS  = 17,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);
  import seg_pkg::*;

  localparam int SLOT_BITS = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(NUM_DIGITS - 1);

  logic [TICK_BITS-1:0]    r_tick;
  logic [SLOT_BITS-1:0]    r_slot;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shadowValue;
  logic [NUM_DIGITS-1:0]   r_shadowDp;
  logic [NUM_DIGITS-1:0]   r_shadowEn;

  logic [NUM_DIGITS-1:0]   r_anodes;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frameStart;

  logic                    w_tickWrap;
  logic                    w_frameWrap;
  logic [NUM_DIGITS-1:0]   w_suppress;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;
  logic [PWM_BITS-1:0]     w_phase;
  logic                    w_visible;
  logic [NUM_DIGITS-1:0]   w_slotSelect;

  assign w_tickWrap  = &r_tick;
  assign w_frameWrap = w_tickWrap && (r_slot == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
      r_slot <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
      if (w_tickWrap) begin
        r_slot <= w_frameWrap ? '0 : r_slot + 1'b1;
      end
    end
  end

  // A load on the wrap cycle itself is consumed by that capture, so it never leaves pending set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= 1'b0;
      r_shadowValue <= '0;
      r_shadowDp    <= '0;
      r_shadowEn    <= '0;
    end else if (w_frameWrap) begin
      if (r_pending || load) begin
        r_shadowValue <= value;
        r_shadowDp    <= dp_in;
        r_shadowEn    <= digit_en;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_pending <= 1'b1;
    end
  end

  // Walk from the most significant digit down; disabled digits read as zero.
  always_comb begin
    logic seenNonZero;
    seenNonZero = 1'b0;
    w_suppress  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_shadowEn[i] && (r_shadowValue[4*i +: 4] != 4'h0)) begin
        seenNonZero = 1'b1;
      end
      w_suppress[i] = blank_lz && !seenNonZero && (i > 0);
    end
  end

  assign w_nibble     = r_shadowValue[{r_slot, 2'b00} +: 4];
  assign w_phase      = r_tick[TICK_BITS-1 -: PWM_BITS];
  assign w_visible    = r_shadowEn[r_slot] && !w_suppress[r_slot] && (w_phase < brightness);
  assign w_slotSelect = ~(NUM_DIGITS'(1) << r_slot);

  hex_to_seg u_hexToSeg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_anodes     <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= (r_slot == '0) && (r_tick == '0);
      if (w_visible) begin
        r_anodes <= w_slotSelect;
        r_seg    <= w_seg;
        r_dp     <= ~r_shadowDp[r_slot];
      end else begin
        r_anodes <= '1;
        r_seg    <= SEG_BLANK;
        r_dp     <= 1'b1;
      end
    end
  end

  assign anodes      = r_anodes;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (4 digits, 16-cycle slots, 2-bit PWM).
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int TB = 4;
  localparam int PB = 2;
  localparam int SLOT_CYCLES  = 1 << TB;
  localparam int FRAME_CYCLES = SLOT_CYCLES * ND;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [15:0]   value;
  logic [3:0]    dpIn;
  logic [3:0]    digitEn;
  logic          blankLz;
  logic [PB-1:0] brightness;
  logic          load;
  logic [3:0]    anodes;
  logic [6:0]    seg;
  logic          dp;
  logic          frameStart;

  seg_scan_display #(.NUM_DIGITS(ND), .TICK_BITS(TB), .PWM_BITS(PB)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dpIn),
    .digit_en    (digitEn),
    .blank_lz    (blankLz),
    .brightness  (brightness),
    .load        (load),
    .anodes      (anodes),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frameStart)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: position is a plain cycle count since reset; shadow holds last captured data.
  int         mState = 0;
  int         mOutIdx = -1;
  logic [15:0] mVal = '0;
  logic [3:0]  mDp = '0;
  logic [3:0]  mEn = '0;
  logic        mPend = 1'b0;
  logic [3:0]  expAn = 4'hF;
  logic [6:0]  expSeg = 7'h7F;
  logic        expDp = 1'b1;
  logic        expFs = 1'b0;

  function automatic logic [6:0] refSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic refSuppressed(input int d);
    if (!blankLz || d == 0) return 1'b0;
    for (int k = ND - 1; k >= d; k--) begin
      if (mEn[k] && mVal[4*k +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelEdge();
    int tick, slot, phase;
    logic vis;
    if (rst) begin
      expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expFs = 1'b0;
      mState = 0; mOutIdx = -1; mVal = '0; mDp = '0; mEn = '0; mPend = 1'b0;
    end else begin
      tick  = mState % SLOT_CYCLES;
      slot  = (mState / SLOT_CYCLES) % ND;
      phase = tick / (SLOT_CYCLES >> PB);
      vis   = mEn[slot] && !refSuppressed(slot) && (phase < int'(brightness));
      expFs = (mState % FRAME_CYCLES == 0);
      if (vis) begin
        expAn  = ~(4'b0001 << slot);
        expSeg = refSeg(mVal[4*slot +: 4]);
        expDp  = ~mDp[slot];
      end else begin
        expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1;
      end
      mOutIdx = mState;
      if (mState % FRAME_CYCLES == FRAME_CYCLES - 1) begin
        if (mPend || load) begin
          mVal = value; mDp = dpIn; mEn = digitEn;
        end
        mPend = 1'b0;
      end else if (load) begin
        mPend = 1'b1;
      end
      mState++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One clock: DUT and model both see the inputs at the edge, outputs compared at the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput($sformatf("idx%0d anodes", mOutIdx), anodes, expAn);
    checkOutput($sformatf("idx%0d seg", mOutIdx), seg, expSeg);
    checkOutput($sformatf("idx%0d dp", mOutIdx), dp, expDp);
    checkOutput($sformatf("idx%0d frame_start", mOutIdx), frameStart, expFs);
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: actual=timeout required=reached", name);
  endtask

  task automatic waitFrameStart();
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (mOutIdx % FRAME_CYCLES != 0 && n < 3 * FRAME_CYCLES);
    if (mOutIdx % FRAME_CYCLES != 0) timeoutFail("frame wait");
  endtask

  task automatic waitOffset(input int off);
    int n = 0;
    while (mOutIdx % FRAME_CYCLES != off && n < 2 * FRAME_CYCLES) begin
      applyStimulus();
      n++;
    end
    if (mOutIdx % FRAME_CYCLES != off) timeoutFail($sformatf("offset %0d wait", off));
  endtask

  task automatic pulseLoad(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value = v; dpIn = d; digitEn = e;
    load = 1'b1;
    applyStimulus();
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpIn;
    logic [3:0]  digitEn;
    logic        blankLz;
    logic [1:0]  bright;
    logic [15:0] expAn;
    logic [27:0] expSeg;
    logic [3:0]  expDp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] randValue();
    logic [15:0] v;
    for (int k = 0; k < ND; k++) begin
      v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    end
    return v;
  endfunction

  initial begin
    int lowCount;
    logic [15:0] lowMask;
    int fsCount;

    rst = 1'b1; value = '0; dpIn = '0; digitEn = '0; blankLz = 1'b0; brightness = '0; load = 1'b0;

    vecs[0] = '{16'h12AF, 4'b0010, 4'hF, 1'b0, 2'd3, 16'h7BDE,
                {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1101};
    vecs[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 2'd3, 16'hFFDE,
                {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'b1111};
    vecs[2] = '{16'h0A03, 4'b1111, 4'b1011, 1'b1, 2'd3, 16'hFFFE,
                {7'h7F, 7'h7F, 7'h7F, 7'b0110000}, 4'b1110};
    vecs[3] = '{16'hFFFF, 4'b1111, 4'hF, 1'b0, 2'd0, 16'hFFFF,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
    vecs[4] = '{16'h0050, 4'b1000, 4'hF, 1'b0, 2'd2, 16'h7BDE,
                {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, 4'b0111};
    vecs[5] = '{16'h0000, 4'b0001, 4'hF, 1'b1, 2'd1, 16'hFFFE,
                {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1110};

    // Reset held three cycles, then dark with no capture.
    repeat (3) applyStimulus();
    checkOutput("reset anodes", anodes, 4'hF);
    checkOutput("reset seg", seg, 7'h7F);
    checkOutput("reset dp", dp, 1'b1);
    checkOutput("reset frame_start", frameStart, 1'b0);
    rst = 1'b0;
    fsCount = 0;
    for (int i = 0; i < 70; i++) begin
      applyStimulus();
      if (frameStart) fsCount++;
    end
    checkOutput("no-load anodes", anodes, 4'hF);
    checkOutput("frame_start count", fsCount, 2);

    for (int v = 0; v < 6; v++) begin
      blankLz = vecs[v].blankLz;
      brightness = vecs[v].bright;
      pulseLoad(vecs[v].value, vecs[v].dpIn, vecs[v].digitEn);
      waitFrameStart();
      for (int s = 0; s < ND; s++) begin
        waitOffset(s * SLOT_CYCLES);
        checkOutput($sformatf("vec%0d slot%0d anodes", v, s), anodes, vecs[v].expAn[4*s +: 4]);
        checkOutput($sformatf("vec%0d slot%0d seg", v, s), seg, vecs[v].expSeg[7*s +: 7]);
        checkOutput($sformatf("vec%0d slot%0d dp", v, s), dp, vecs[v].expDp[s]);
      end
    end

    // PWM duty: brightness 1 lights the first quarter of each slot only.
    blankLz = 1'b0;
    brightness = 2'd1;
    pulseLoad(16'h12AF, 4'b0000, 4'hF);
    waitFrameStart();
    lowMask = '0;
    for (int i = 0; i < SLOT_CYCLES; i++) begin
      lowMask[i] = (anodes != 4'hF);
      applyStimulus();
    end
    checkOutput("pwm low mask", lowMask, 16'h000F);
    brightness = 2'd0;
    lowCount = 0;
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      applyStimulus();
      if (anodes != 4'hF) lowCount++;
    end
    checkOutput("brightness0 low count", lowCount, 0);

    // Mid-frame load keeps the old digits until the next frame_start.
    brightness = 2'd3;
    pulseLoad(16'h12AF, 4'b0000, 4'hF);
    waitFrameStart();
    waitOffset(SLOT_CYCLES);
    pulseLoad(16'h3456, 4'b0000, 4'hF);
    waitOffset(3 * SLOT_CYCLES);
    checkOutput("midload old anodes", anodes, 4'h7);
    checkOutput("midload old seg", seg, 7'b1111001);
    waitFrameStart();
    checkOutput("midload frame_start", frameStart, 1'b1);
    checkOutput("midload new anodes", anodes, 4'hE);
    checkOutput("midload new seg", seg, 7'b0000010);

    // Reset in slot 2: dark immediately, slot restarts at 0 with shadow cleared.
    waitOffset(2 * SLOT_CYCLES + 5);
    rst = 1'b1;
    applyStimulus();
    checkOutput("midreset anodes", anodes, 4'hF);
    checkOutput("midreset seg", seg, 7'h7F);
    checkOutput("midreset frame_start", frameStart, 1'b0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("post-reset frame_start", frameStart, 1'b1);
    checkOutput("post-reset anodes", anodes, 4'hF);

    // Randomized traffic against the model.
    for (int c = 0; c < 1200; c++) begin
      if (c % 8 == 0) begin
        value = randValue();
        dpIn = 4'($urandom);
        digitEn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
      if (c % 23 == 0) brightness = PB'($urandom);
      if (c % 57 == 0) blankLz = 1'($urandom);
      load = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus();
    end
    load = 1'b0;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed driver for the board's common-anode seven-segment bank. It scans `NUM_DIGITS` hex digits and adds the following:
- per-digit enable and decimal point;
- optional leading-zero blanking;
- PWM brightness control;
- tear-free value updates, where new values are latched only at frame boundaries.

It sits between the game/score logic and the display pins, and supersedes the fixed 8-digit scanner.

## Interface
Parameters:
- `NUM_DIGITS`, 8, number of digits scanned (1..8)
- `TICK_BITS`, 17, log2 of clock cycles per digit slot
- `PWM_BITS`, 4, brightness resolution; must satisfy `PWM_BITS <= TICK_BITS`

Ports:
- `clk` in 1: system clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `value` in 4*NUM_DIGITS: hex nibbles; digit i is `value[4i+3:4i]`, and digit 0 is rightmost.
- `dp_in` in NUM_DIGITS: 1 lights the decimal point of digit i.
- `digit_en` in NUM_DIGITS: 0 forces digit i dark.
- `blank_lz` in 1: 1 enables leading-zero suppression.
- `brightness` in PWM_BITS: 0 = dark; 2^PWM_BITS-1 = maximum brightness.
- `load` in 1: single-cycle request to capture `value`, `dp_in` and `digit_en`.
- `anodes` out NUM_DIGITS: active-low digit selects.
- `seg` out 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- `dp` out 1: active-low decimal point.
- `frame_start` out 1: one-cycle pulse when slot 0 begins.

## Operation
- **Tick counter** (TICK_BITS wide): increments every cycle and wraps freely. At wrap, the slot counter advances.
- **Slot counter**: counts 0..NUM_DIGITS-1, then wraps to 0. A frame is NUM_DIGITS slots long.
- **Load handling**: `load` sets a pending flag.
  - On the cycle the slot wraps NUM_DIGITS-1 → 0, if pending is set, the shadow registers capture the current `value`, `dp_in` and `digit_en`, and pending clears.
  - A `load` on that same cycle counts as the captured request; no extra pending flag is left behind.
  - Repeated `load` pulses within one frame collapse into a single capture.
- **Digit visibility**: digit i is visible iff all of the following hold:
  - its shadow enable bit is 1;
  - it is not a suppressed leading zero;
  - the PWM phase is below `brightness`.
- **Leading-zero suppression** (`blank_lz`=1):
  - Digit i is suppressed when every shadow nibble from NUM_DIGITS-1 down to i is 0, and i > 0.
  - Digit 0 is never suppressed.
  - Disabled digits count as zero for this rule.
  - A suppressed digit also hides its dp.
- **PWM**: phase = `tick[TICK_BITS-1 -: PWM_BITS]`.
  - The digit is lit when phase < `brightness`, giving brightness/2^PWM_BITS duty within each slot.
  - `brightness` is sampled live, not shadowed.
- **Visible digit**: `anodes` is low only at the current slot's bit. `seg` carries the hex decode of the shadow nibble, and `dp` = NOT shadow `dp_in`[slot].
- **Invisible digit**: `anodes` is all 1, `seg` = 7'h7F, `dp` = 1.
- **Hex decode**:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110

## Timing
- **Reset values**:
  - Internal state: tick=0, slot=0, shadow value/dp=0, shadow enable=0, pending=0.
  - Outputs: `anodes`=all 1, `seg`=7'h7F, `dp`=1, `frame_start`=0.
- **Reset precedence**: `rst` overrides `load`. Asserting it mid-frame returns the block to slot 0 on the next cycle, with all digits dark until a load is captured.
- **Output latency**: all outputs are registered and lag the internal tick/slot state by one cycle.
- **`frame_start`**: high on exactly the first output cycle of slot 0, i.e. one cycle after the wrap/capture edge.
- **Update timing**: captured data appears on the outputs on that same first cycle of slot 0. Between captures, the display shows the old shadow contents unchanged, with no partial-frame mixing.
- **Dark outputs**:
  - `brightness`=0: `anodes` are never driven low.
  - `brightness`=2^PWM_BITS-1: a digit is dark for 1/2^PWM_BITS of its slot. This gap doubles as inter-digit ghost blanking.

## Structure
- A shared package `seg_pkg` holds the segment constants (`SEG_BLANK`=7'h7F) and the hex-to-segment decode function.
- The sub-module `hex_to_seg` (combinational, 4 bits in, 7 bits out) is instantiated once on the muxed shadow nibble.
- The top level contains the counters, pending/shadow registers, leading-zero logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_BITS=4, PWM_BITS=2.
- **Reset**: hold `rst` for 3 cycles → `anodes`=4'hF, `seg`=7'h7F, `dp`=1, `frame_start`=0. This persists while no load has been captured.
- **Basic scan**: `load` with `value`=16'h12AF, `digit_en`=4'hF, `dp_in`=4'b0010, `brightness`=3 → after the frame boundary:
  - slot 0: `anodes`=1110, `seg`=0001110;
  - slot 1: `anodes`=1101, `seg`=0001000, `dp`=0;
  - slot 3: `anodes`=0111, `seg`=1111001.
- **Leading-zero blanking**: `value`=16'h0050, `blank_lz`=1 → slots 3 and 2 keep `anodes`=all 1; slot 1 shows 0010010; slot 0 shows 1000000.
- **PWM duty**: `brightness`=1 → within each 16-cycle slot, the digit's anode is low for exactly 4 cycles, namely tick phases 0..3. `brightness`=0 → anodes never go low.
- **Mid-frame load**: pulse `load` during slot 1 with a new value → outputs keep the old digits through slot 3. The new value appears on the same cycle `frame_start` pulses.
- **Reset mid-frame**: assert `rst` in slot 2 → the next output cycle is all dark, and the slot restarts at 0.
